// File: rtl/decode_stage.sv
// RV32I decode stage: instruction/PC FIFO feeding a registered decode bundle with valid/ready.
// Defining DECODE_RV32M_EN adds decode of the RV32M multiply/divide group.
`timescale 1ns/1ps
module decode_stage #(
  parameter  int XLEN  = 32,
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             if_valid,
  output logic             if_ready,
  input  logic [31:0]      if_inst,
  input  logic [XLEN-1:0]  if_pc,
  input  logic             flush,
  output logic             id_valid,
  input  logic             id_ready,
  output logic [XLEN-1:0]  id_pc,
  output logic [XLEN-1:0]  id_imm,
  output logic [4:0]       id_rs1_addr,
  output logic [4:0]       id_rs2_addr,
  output logic [4:0]       id_rd_addr,
  output logic [4:0]       id_exe_fun,
  output logic [1:0]       id_op1_sel,
  output logic [2:0]       id_op2_sel,
  output logic             id_mem_wen,
  output logic             id_rf_wen,
  output logic [1:0]       id_wb_sel,
  output logic             id_illegal,
  output logic [PTR_W:0]   fifo_count
);

  localparam logic [4:0] ALU_X    = 5'd0;
  localparam logic [4:0] ALU_ADD  = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_AND  = 5'd3;
  localparam logic [4:0] ALU_OR   = 5'd4;
  localparam logic [4:0] ALU_XOR  = 5'd5;
  localparam logic [4:0] ALU_SLL  = 5'd6;
  localparam logic [4:0] ALU_SRL  = 5'd7;
  localparam logic [4:0] ALU_SRA  = 5'd8;
  localparam logic [4:0] ALU_SLT  = 5'd9;
  localparam logic [4:0] ALU_SLTU = 5'd10;
  localparam logic [4:0] BR_BEQ   = 5'd11;
  localparam logic [4:0] ALU_JALR = 5'd17;
`ifdef DECODE_RV32M_EN
  localparam logic [4:0] ALU_MUL  = 5'd18;
`endif

  localparam logic [1:0] RS1_X   = 2'd0;
  localparam logic [1:0] RS1_RS1 = 2'd1;
  localparam logic [1:0] RS1_PC  = 2'd2;
  localparam logic [2:0] RS2_X   = 3'd0;
  localparam logic [2:0] RS2_RS2 = 3'd1;
  localparam logic [2:0] RS2_IMI = 3'd2;
  localparam logic [2:0] RS2_IMS = 3'd3;
  localparam logic [2:0] RS2_IMJ = 3'd4;
  localparam logic [2:0] RS2_IMU = 3'd5;
  localparam logic [1:0] WB_X    = 2'd0;
  localparam logic [1:0] WB_ALU  = 2'd0;
  localparam logic [1:0] WB_MEM  = 2'd1;
  localparam logic [1:0] WB_PC   = 2'd2;
  localparam logic       MEN_X   = 1'b0;
  localparam logic       MEN_S   = 1'b1;
  localparam logic       REN_X   = 1'b0;
  localparam logic       REN_S   = 1'b1;

  localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

  logic [31:0]      fifo_inst [DEPTH];
  logic [XLEN-1:0]  fifo_pc   [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             push, pop;

  logic [31:0] head_inst;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [31:0] dec_imm;
  logic [4:0]  dec_exe;
  logic [1:0]  dec_op1;
  logic [2:0]  dec_op2;
  logic        dec_mem, dec_rf, dec_ill;
  logic [1:0]  dec_wb;

  // Flush keeps the fetch side open so the redirected stream can start immediately.
  assign if_ready = flush || (fifo_count != FULL_COUNT);
  assign push     = if_valid && if_ready && !flush;
  assign pop      = (fifo_count != '0) && (!id_valid || id_ready);

  assign head_inst = fifo_inst[rd_ptr];
  assign opcode    = head_inst[6:0];
  assign funct3    = head_inst[14:12];
  assign funct7    = head_inst[31:25];
  assign imm_i = {{20{head_inst[31]}}, head_inst[31:20]};
  assign imm_s = {{20{head_inst[31]}}, head_inst[31:25], head_inst[11:7]};
  assign imm_b = {{19{head_inst[31]}}, head_inst[31], head_inst[7], head_inst[30:25],
                  head_inst[11:8], 1'b0};
  assign imm_u = {head_inst[31:12], 12'b0};
  assign imm_j = {{11{head_inst[31]}}, head_inst[31], head_inst[19:12], head_inst[20],
                  head_inst[30:21], 1'b0};

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_inst[wr_ptr] <= if_inst;
      fifo_pc[wr_ptr]   <= if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_comb begin
    dec_imm = '0;
    dec_exe = ALU_X;
    dec_op1 = RS1_X;
    dec_op2 = RS2_X;
    dec_mem = MEN_X;
    dec_rf  = REN_X;
    dec_wb  = WB_X;
    dec_ill = 1'b0;
    case (opcode)
      7'b0110111: begin
        dec_imm = imm_u; dec_exe = ALU_ADD; dec_op2 = RS2_IMU; dec_rf = REN_S; dec_wb = WB_ALU;
      end
      7'b0010111: begin
        dec_imm = imm_u; dec_exe = ALU_ADD; dec_op1 = RS1_PC; dec_op2 = RS2_IMU;
        dec_rf = REN_S; dec_wb = WB_ALU;
      end
      7'b1101111: begin
        dec_imm = imm_j; dec_exe = ALU_ADD; dec_op1 = RS1_PC; dec_op2 = RS2_IMJ;
        dec_rf = REN_S; dec_wb = WB_PC;
      end
      7'b1100111: begin
        dec_imm = imm_i; dec_exe = ALU_JALR; dec_op1 = RS1_RS1; dec_op2 = RS2_IMI;
        dec_rf = REN_S; dec_wb = WB_PC;
        if (funct3 != 3'b000) dec_ill = 1'b1;
      end
      7'b1100011: begin
        // BR_* codes are contiguous in funct3 order once the two reserved funct3 values are skipped.
        dec_imm = imm_b; dec_op1 = RS1_RS1; dec_op2 = RS2_RS2;
        case (funct3)
          3'b000, 3'b001: dec_exe = BR_BEQ + {4'b0000, funct3[0]};
          3'b100, 3'b101, 3'b110, 3'b111: dec_exe = BR_BEQ + {3'b000, funct3[1:0]} + 5'd2;
          default: dec_ill = 1'b1;
        endcase
      end
      7'b0000011: begin
        dec_imm = imm_i; dec_exe = ALU_ADD; dec_op1 = RS1_RS1; dec_op2 = RS2_IMI;
        dec_rf = REN_S; dec_wb = WB_MEM;
        if (funct3 != 3'b010) dec_ill = 1'b1;
      end
      7'b0100011: begin
        dec_imm = imm_s; dec_exe = ALU_ADD; dec_op1 = RS1_RS1; dec_op2 = RS2_IMS; dec_mem = MEN_S;
        if (funct3 != 3'b010) dec_ill = 1'b1;
      end
      7'b0010011: begin
        dec_imm = imm_i; dec_op1 = RS1_RS1; dec_op2 = RS2_IMI; dec_rf = REN_S; dec_wb = WB_ALU;
        case (funct3)
          3'b000:  dec_exe = ALU_ADD;
          3'b010:  dec_exe = ALU_SLT;
          3'b011:  dec_exe = ALU_SLTU;
          3'b100:  dec_exe = ALU_XOR;
          3'b110:  dec_exe = ALU_OR;
          3'b111:  dec_exe = ALU_AND;
          3'b001:  if (funct7 == 7'h00) dec_exe = ALU_SLL; else dec_ill = 1'b1;
          default: begin
            if      (funct7 == 7'h00) dec_exe = ALU_SRL;
            else if (funct7 == 7'h20) dec_exe = ALU_SRA;
            else                      dec_ill = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        dec_op1 = RS1_RS1; dec_op2 = RS2_RS2; dec_rf = REN_S; dec_wb = WB_ALU;
        if (funct7 == 7'h00) begin
          case (funct3)
            3'b000:  dec_exe = ALU_ADD;
            3'b001:  dec_exe = ALU_SLL;
            3'b010:  dec_exe = ALU_SLT;
            3'b011:  dec_exe = ALU_SLTU;
            3'b100:  dec_exe = ALU_XOR;
            3'b101:  dec_exe = ALU_SRL;
            3'b110:  dec_exe = ALU_OR;
            default: dec_exe = ALU_AND;
          endcase
        end else if (funct7 == 7'h20) begin
          case (funct3)
            3'b000:  dec_exe = ALU_SUB;
            3'b101:  dec_exe = ALU_SRA;
            default: dec_ill = 1'b1;
          endcase
`ifdef DECODE_RV32M_EN
        end else if (funct7 == 7'h01) begin
          dec_exe = ALU_MUL + {2'b00, funct3};
`endif
        end else begin
          dec_ill = 1'b1;
        end
      end
      default: dec_ill = 1'b1;
    endcase
    // An illegal bundle carries no side effects downstream.
    if (dec_ill) begin
      dec_imm = '0;
      dec_exe = ALU_X;
      dec_op1 = RS1_X;
      dec_op2 = RS2_X;
      dec_mem = MEN_X;
      dec_rf  = REN_X;
      dec_wb  = WB_X;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      id_valid    <= 1'b0;
      id_pc       <= '0;
      id_imm      <= '0;
      id_rs1_addr <= '0;
      id_rs2_addr <= '0;
      id_rd_addr  <= '0;
      id_exe_fun  <= ALU_X;
      id_op1_sel  <= RS1_X;
      id_op2_sel  <= RS2_X;
      id_mem_wen  <= MEN_X;
      id_rf_wen   <= REN_X;
      id_wb_sel   <= WB_X;
      id_illegal  <= 1'b0;
    end else if (pop) begin
      id_valid    <= 1'b1;
      id_pc       <= fifo_pc[rd_ptr];
      id_imm      <= dec_imm;
      id_rs1_addr <= head_inst[19:15];
      id_rs2_addr <= head_inst[24:20];
      id_rd_addr  <= head_inst[11:7];
      id_exe_fun  <= dec_exe;
      id_op1_sel  <= dec_op1;
      id_op2_sel  <= dec_op2;
      id_mem_wen  <= dec_mem;
      id_rf_wen   <= dec_rf;
      id_wb_sel   <= dec_wb;
      id_illegal  <= dec_ill;
    end else if (id_ready) begin
      id_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: decode vector table plus backpressure, flush and reset sequences.
`timescale 1ns/1ps
module tb_decode_stage;

  localparam logic [4:0] ALU_X = 5'd0, ALU_ADD = 5'd1, ALU_SUB = 5'd2, ALU_XOR = 5'd5;
  localparam logic [4:0] ALU_SRA = 5'd8, BR_BEQ = 5'd11, BR_BGEU = 5'd16, ALU_JALR = 5'd17;
  localparam logic [4:0] ALU_MUL = 5'd18;
  localparam logic [1:0] RS1_X = 2'd0, RS1_RS1 = 2'd1, RS1_PC = 2'd2;
  localparam logic [2:0] RS2_X = 3'd0, RS2_RS2 = 3'd1, RS2_IMI = 3'd2, RS2_IMS = 3'd3;
  localparam logic [2:0] RS2_IMJ = 3'd4, RS2_IMU = 3'd5;
  localparam logic [1:0] WB_X = 2'd0, WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC = 2'd2;
  localparam int NVEC = 18;

  logic        clk = 1'b0;
  logic        rst_n, if_valid, if_ready, flush, id_valid, id_ready;
  logic [31:0] if_inst, if_pc, id_pc, id_imm;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr, id_exe_fun;
  logic [1:0]  id_op1_sel, id_wb_sel;
  logic [2:0]  id_op2_sel;
  logic        id_mem_wen, id_rf_wen, id_illegal;
  logic [2:0]  fifo_count;

  typedef logic [93:0] bundle_t;
  typedef struct {
    logic [31:0] inst;
    logic [31:0] imm;
    logic [4:0]  exe;
    logic [1:0]  op1;
    logic [2:0]  op2;
    logic        mem;
    logic        rf;
    logic [1:0]  wb;
    logic        ill;
  } vec_t;

  vec_t    vecs [NVEC];
  bundle_t sb [$];
  bundle_t mon_exp;
  int      checks = 0;
  int      failures = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_valid(if_valid), .if_ready(if_ready),
    .if_inst(if_inst), .if_pc(if_pc), .flush(flush), .id_valid(id_valid),
    .id_ready(id_ready), .id_pc(id_pc), .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr), .id_exe_fun(id_exe_fun),
    .id_op1_sel(id_op1_sel), .id_op2_sel(id_op2_sel), .id_mem_wen(id_mem_wen),
    .id_rf_wen(id_rf_wen), .id_wb_sel(id_wb_sel), .id_illegal(id_illegal),
    .fifo_count(fifo_count)
  );

  function automatic bundle_t dutBundle();
    return {id_pc, id_imm, id_rs1_addr, id_rs2_addr, id_rd_addr, id_exe_fun,
            id_op1_sel, id_op2_sel, id_mem_wen, id_rf_wen, id_wb_sel, id_illegal};
  endfunction

  function automatic bundle_t expectBundle(input vec_t v, input logic [31:0] pc);
    return {pc, v.imm, v.inst[19:15], v.inst[24:20], v.inst[11:7], v.exe,
            v.op1, v.op2, v.mem, v.rf, v.wb, v.ill};
  endfunction

  task automatic checkOutput(input string name, input bundle_t act, input bundle_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
    end
  endtask

  // Drive one instruction until the FIFO accepts it, then queue its expected bundle.
  task automatic applyStimulus(input vec_t v, input logic [31:0] pc);
    bit ok = 1'b0;
    bit accepted = 1'b0;
    if_valid = 1'b1;
    if_inst  = v.inst;
    if_pc    = pc;
    for (int w = 0; w < 50 && !accepted; w++) begin
      @(negedge clk);
      ok = if_ready && !flush;
      @(posedge clk);
      #1;
      accepted = ok;
    end
    if_valid = 1'b0;
    if (accepted) sb.push_back(expectBundle(v, pc));
    else checkOutput("accept_timeout", bundle_t'(0), bundle_t'(1));
  endtask

  task automatic waitDrain(input string name);
    for (int w = 0; w < 40 && sb.size() != 0; w++) @(posedge clk);
    #1;
    checkOutput(name, bundle_t'(sb.size()), bundle_t'(0));
  endtask

  always @(negedge clk) begin
    if (rst_n && !flush && id_valid && id_ready) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_bundle", dutBundle(), bundle_t'(0));
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("bundle", dutBundle(), mon_exp);
      end
    end
  end

  initial begin
    vecs[0]  = '{32'h00500093, 32'd5,        ALU_ADD,  RS1_RS1, RS2_IMI, 1'b0, 1'b1, WB_ALU, 1'b0};
    vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC, BR_BEQ,   RS1_RS1, RS2_RS2, 1'b0, 1'b0, WB_X,   1'b0};
    vecs[2]  = '{32'h0000A063, 32'd0,        ALU_X,    RS1_X,   RS2_X,   1'b0, 1'b0, WB_X,   1'b1};
    vecs[3]  = '{32'h0000A003, 32'd0,        ALU_ADD,  RS1_RS1, RS2_IMI, 1'b0, 1'b1, WB_MEM, 1'b0};
`ifdef DECODE_RV32M_EN
    vecs[4]  = '{32'h02208033, 32'd0,        ALU_MUL,  RS1_RS1, RS2_RS2, 1'b0, 1'b1, WB_ALU, 1'b0};
`else
    vecs[4]  = '{32'h02208033, 32'd0,        ALU_X,    RS1_X,   RS2_X,   1'b0, 1'b0, WB_X,   1'b1};
`endif
    vecs[5]  = '{32'h0020A423, 32'd8,        ALU_ADD,  RS1_RS1, RS2_IMS, 1'b1, 1'b0, WB_X,   1'b0};
    vecs[6]  = '{32'h00208423, 32'd0,        ALU_X,    RS1_X,   RS2_X,   1'b0, 1'b0, WB_X,   1'b1};
    vecs[7]  = '{32'h123452B7, 32'h12345000, ALU_ADD,  RS1_X,   RS2_IMU, 1'b0, 1'b1, WB_ALU, 1'b0};
    vecs[8]  = '{32'hFFFFF197, 32'hFFFFF000, ALU_ADD,  RS1_PC,  RS2_IMU, 1'b0, 1'b1, WB_ALU, 1'b0};
    vecs[9]  = '{32'hFF9FF0EF, 32'hFFFFFFF8, ALU_ADD,  RS1_PC,  RS2_IMJ, 1'b0, 1'b1, WB_PC,  1'b0};
    vecs[10] = '{32'h00C08067, 32'd12,       ALU_JALR, RS1_RS1, RS2_IMI, 1'b0, 1'b1, WB_PC,  1'b0};
    vecs[11] = '{32'h402081B3, 32'd0,        ALU_SUB,  RS1_RS1, RS2_RS2, 1'b0, 1'b1, WB_ALU, 1'b0};
    vecs[12] = '{32'h4030D213, 32'h00000403, ALU_SRA,  RS1_RS1, RS2_IMI, 1'b0, 1'b1, WB_ALU, 1'b0};
    vecs[13] = '{32'h40309213, 32'd0,        ALU_X,    RS1_X,   RS2_X,   1'b0, 1'b0, WB_X,   1'b1};
    vecs[14] = '{32'h20208033, 32'd0,        ALU_X,    RS1_X,   RS2_X,   1'b0, 1'b0, WB_X,   1'b1};
    vecs[15] = '{32'h0000007F, 32'd0,        ALU_X,    RS1_X,   RS2_X,   1'b0, 1'b0, WB_X,   1'b1};
    vecs[16] = '{32'hFFF0C113, 32'hFFFFFFFF, ALU_XOR,  RS1_RS1, RS2_IMI, 1'b0, 1'b1, WB_ALU, 1'b0};
    vecs[17] = '{32'h0020F863, 32'd16,       BR_BGEU,  RS1_RS1, RS2_RS2, 1'b0, 1'b0, WB_X,   1'b0};

    rst_n = 1'b0; if_valid = 1'b0; flush = 1'b0; id_ready = 1'b0;
    if_inst = '0; if_pc = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    checkOutput("reset_valid", bundle_t'(id_valid), bundle_t'(0));
    checkOutput("reset_count", bundle_t'(fifo_count), bundle_t'(0));
    checkOutput("reset_bundle", dutBundle(), bundle_t'(0));
    checkOutput("reset_if_ready", bundle_t'(if_ready), bundle_t'(1));

    // Two-edge latency from acceptance to a valid bundle.
    id_ready = 1'b1;
    applyStimulus(vecs[0], 32'h0);
    checkOutput("lat_count_after_push", bundle_t'(fifo_count), bundle_t'(1));
    checkOutput("lat_not_yet_valid", bundle_t'(id_valid), bundle_t'(0));
    @(posedge clk); #1;
    checkOutput("lat_valid", bundle_t'(id_valid), bundle_t'(1));
    checkOutput("lat_imm", bundle_t'(id_imm), bundle_t'(5));
    waitDrain("lat_drain");

    for (int i = 0; i < NVEC; i++) applyStimulus(vecs[i], 32'h100 + 32'(4 * i));
    waitDrain("table_drain");

    // Backpressure: DEPTH+1 pushes fill the FIFO and the output register.
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(vecs[(i * 5) % NVEC], 32'(4 * i));
    checkOutput("full_count", bundle_t'(fifo_count), bundle_t'(4));
    checkOutput("full_if_ready", bundle_t'(if_ready), bundle_t'(0));
    checkOutput("full_valid", bundle_t'(id_valid), bundle_t'(1));
    id_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stream_valid", bundle_t'(id_valid), bundle_t'(1));
    end
    @(posedge clk); #1;
    checkOutput("stream_end_valid", bundle_t'(id_valid), bundle_t'(0));
    waitDrain("stream_drain");

    // Flush on a full FIFO with a simultaneous push.
    id_ready = 1'b0;
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i + 7], 32'h200 + 32'(4 * i));
    flush = 1'b1; if_valid = 1'b1; if_inst = 32'h00700113; if_pc = 32'h300;
    @(negedge clk);
    checkOutput("flush_if_ready", bundle_t'(if_ready), bundle_t'(1));
    @(posedge clk); #1;
    flush = 1'b0; if_valid = 1'b0;
    sb.delete();
    checkOutput("flush_count", bundle_t'(fifo_count), bundle_t'(0));
    checkOutput("flush_valid", bundle_t'(id_valid), bundle_t'(0));
    id_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("flush_nothing_out", bundle_t'(id_valid), bundle_t'(0));
    end

    // Reset while three entries are buffered and a bundle is held.
    @(posedge clk); #1;
    id_ready = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(vecs[i + 8], 32'h400 + 32'(4 * i));
    checkOutput("pre_reset_count", bundle_t'(fifo_count), bundle_t'(3));
    checkOutput("pre_reset_valid", bundle_t'(id_valid), bundle_t'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    checkOutput("midreset_valid", bundle_t'(id_valid), bundle_t'(0));
    checkOutput("midreset_count", bundle_t'(fifo_count), bundle_t'(0));
    checkOutput("midreset_bundle", dutBundle(), bundle_t'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("post_reset_if_ready", bundle_t'(if_ready), bundle_t'(1));

    id_ready = 1'b1;
    applyStimulus(vecs[1], 32'h500);
    waitDrain("final_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
